// File: rtl/wshb_arbiter.sv
// Two-master / one-slave classic Wishbone arbiter with registered one-hot grant,
// fair alternation on ties and optional ack-count preemption.
module wshb_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 64
) (
    input  logic            CLK,
    input  logic            NRST,

    input  logic            m0_cyc,
    input  logic            m0_stb,
    input  logic            m0_we,
    input  logic [AW-1:0]   m0_adr,
    input  logic [DW-1:0]   m0_dat_ms,
    input  logic [DW/8-1:0] m0_sel,
    output logic [DW-1:0]   m0_dat_sm,
    output logic            m0_ack,

    input  logic            m1_cyc,
    input  logic            m1_stb,
    input  logic            m1_we,
    input  logic [AW-1:0]   m1_adr,
    input  logic [DW-1:0]   m1_dat_ms,
    input  logic [DW/8-1:0] m1_sel,
    output logic [DW-1:0]   m1_dat_sm,
    output logic            m1_ack,

    output logic            s_cyc,
    output logic            s_stb,
    output logic            s_we,
    output logic [AW-1:0]   s_adr,
    output logic [DW-1:0]   s_dat_ms,
    output logic [DW/8-1:0] s_sel,
    input  logic [DW-1:0]   s_dat_sm,
    input  logic            s_ack,

    output logic [1:0]      gnt
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] G0   = 2'b01;
    localparam logic [1:0] G1   = 2'b10;

    localparam int CW  = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam int PRE = (MAX_BURST > 0) ? MAX_BURST - 1 : 0;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
    localparam logic [CW-1:0] CNT_PRE = CW'(PRE);

    logic [1:0]    state_q, state_d;
    logic          last_q, last_d;     // 1 = M1 served last
    logic [CW-1:0] cnt_q, cnt_d;

    logic g0, g1;
    logic ack0, ack1;
    logic burst_done;

    assign g0 = (state_q == G0);
    assign g1 = (state_q == G1);

    // Acks are only forwarded to the granted master while it still holds cyc.
    assign ack0 = g0 & s_ack & m0_cyc;
    assign ack1 = g1 & s_ack & m1_cyc;

    // Saturated counter keeps this true until the other master shows up.
    assign burst_done = (MAX_BURST > 0) && (cnt_q >= CNT_PRE);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    state_d = last_q ? G0 : G1;
                end else if (m0_cyc) begin
                    state_d = G0;
                end else if (m1_cyc) begin
                    state_d = G1;
                end
            end
            G0: begin
                if (!m0_cyc) begin
                    state_d = m1_cyc ? G1 : IDLE;
                    last_d  = 1'b0;
                end else if (ack0 && m1_cyc && burst_done) begin
                    state_d = G1;
                    last_d  = 1'b0;
                end
            end
            G1: begin
                if (!m1_cyc) begin
                    state_d = m0_cyc ? G0 : IDLE;
                    last_d  = 1'b1;
                end else if (ack1 && m0_cyc && burst_done) begin
                    state_d = G0;
                    last_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((ack0 || ack1) && (cnt_q < CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt = state_q;

    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_dat_ms = '0;
        s_sel    = '0;
        if (g0) begin
            s_cyc    = m0_cyc;
            s_stb    = m0_stb;
            s_we     = m0_we;
            s_adr    = m0_adr;
            s_dat_ms = m0_dat_ms;
            s_sel    = m0_sel;
        end else if (g1) begin
            s_cyc    = m1_cyc;
            s_stb    = m1_stb;
            s_we     = m1_we;
            s_adr    = m1_adr;
            s_dat_ms = m1_dat_ms;
            s_sel    = m1_sel;
        end
    end

    assign m0_ack    = ack0;
    assign m1_ack    = ack1;
    assign m0_dat_sm = s_dat_sm;
    assign m1_dat_sm = s_dat_sm;

endmodule

// File: tb/tb_wshb_arbiter.sv
// Bench for wshb_arbiter: table of per-cycle vectors plus slave/master models
// for multi-cycle burst, preemption and reset scenarios.
module tb_wshb_arbiter;

    logic CLK = 1'b0;
    logic NRST;
    always #5 CLK = ~CLK;

    logic        m0_run, m1_run;
    logic        m0_ld, m1_ld;
    logic [31:0] m0_base, m1_base;
    logic [31:0] m0_adr, m1_adr;
    logic [31:0] m0_dat_ms, m1_dat_ms;
    logic        tb_ack, ack_auto, use_z, sb_clr;
    logic        slv_ack = 1'b0, slv_ack_z = 1'b0;

    logic [31:0] m0_dat_sm, m1_dat_sm, s_adr, s_dat_ms, s_dat_sm;
    logic        m0_ack, m1_ack, s_cyc, s_stb, s_we, s_ack;
    logic [3:0]  s_sel;
    logic [1:0]  gnt;

    logic [31:0] m0_dat_sm_z, m1_dat_sm_z, s_adr_z, s_dat_ms_z, s_dat_sm_z;
    logic        m0_ack_z, m1_ack_z, s_cyc_z, s_stb_z, s_we_z, s_ack_z;
    logic [3:0]  s_sel_z;
    logic [1:0]  gnt_z;

    assign m0_dat_ms  = m0_adr ^ 32'h0F0F_0000;
    assign m1_dat_ms  = m1_adr ^ 32'h0F0F_0000;
    assign s_dat_sm   = ~s_adr;
    assign s_dat_sm_z = ~s_adr_z;
    assign s_ack      = ack_auto ? slv_ack   : tb_ack;
    assign s_ack_z    = ack_auto ? slv_ack_z : tb_ack;

    wshb_arbiter #(.AW(32), .DW(32), .MAX_BURST(4)) u_dut (
        .CLK(CLK), .NRST(NRST),
        .m0_cyc(m0_run), .m0_stb(m0_run), .m0_we(1'b0), .m0_adr(m0_adr),
        .m0_dat_ms(m0_dat_ms), .m0_sel(4'hF), .m0_dat_sm(m0_dat_sm), .m0_ack(m0_ack),
        .m1_cyc(m1_run), .m1_stb(m1_run), .m1_we(1'b1), .m1_adr(m1_adr),
        .m1_dat_ms(m1_dat_ms), .m1_sel(4'h3), .m1_dat_sm(m1_dat_sm), .m1_ack(m1_ack),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_dat_sm(s_dat_sm), .s_ack(s_ack),
        .gnt(gnt)
    );

    wshb_arbiter #(.AW(32), .DW(32), .MAX_BURST(0)) u_dut_z (
        .CLK(CLK), .NRST(NRST),
        .m0_cyc(m0_run), .m0_stb(m0_run), .m0_we(1'b0), .m0_adr(m0_adr),
        .m0_dat_ms(m0_dat_ms), .m0_sel(4'hF), .m0_dat_sm(m0_dat_sm_z), .m0_ack(m0_ack_z),
        .m1_cyc(m1_run), .m1_stb(m1_run), .m1_we(1'b1), .m1_adr(m1_adr),
        .m1_dat_ms(m1_dat_ms), .m1_sel(4'h3), .m1_dat_sm(m1_dat_sm_z), .m1_ack(m1_ack_z),
        .s_cyc(s_cyc_z), .s_stb(s_stb_z), .s_we(s_we_z), .s_adr(s_adr_z),
        .s_dat_ms(s_dat_ms_z), .s_sel(s_sel_z), .s_dat_sm(s_dat_sm_z), .s_ack(s_ack_z),
        .gnt(gnt_z)
    );

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Slave acks one cycle after seeing cyc&stb, as a single-cycle pulse.
    always @(posedge CLK) begin
        slv_ack   <= s_cyc & s_stb & ~slv_ack;
        slv_ack_z <= s_cyc_z & s_stb_z & ~slv_ack_z;
    end

    // Masters advance their address on each completed transfer.
    always @(posedge CLK) begin
        if (m0_ld) m0_adr <= m0_base;
        else if (ack_auto && (use_z ? m0_ack_z : m0_ack)) m0_adr <= m0_adr + 32'd4;
        if (m1_ld) m1_adr <= m1_base;
        else if (ack_auto && (use_z ? m1_ack_z : m1_ack)) m1_adr <= m1_adr + 32'd4;
    end

    logic        mon_a0, mon_a1, mon_we;
    logic [31:0] mon_adr, mon_dms, mon_d0, mon_d1;
    logic [3:0]  mon_sel;
    assign mon_a0  = use_z ? m0_ack_z    : m0_ack;
    assign mon_a1  = use_z ? m1_ack_z    : m1_ack;
    assign mon_we  = use_z ? s_we_z      : s_we;
    assign mon_adr = use_z ? s_adr_z     : s_adr;
    assign mon_dms = use_z ? s_dat_ms_z  : s_dat_ms;
    assign mon_d0  = use_z ? m0_dat_sm_z : m0_dat_sm;
    assign mon_d1  = use_z ? m1_dat_sm_z : m1_dat_sm;
    assign mon_sel = use_z ? s_sel_z     : s_sel;

    int          n0, n1;
    logic [31:0] sb0, sb1;

    // Scoreboard: each acked transfer must be the next sequential address of that master.
    always @(negedge CLK) begin
        if (sb_clr) begin
            n0 = 0; n1 = 0; sb0 = m0_base; sb1 = m1_base;
        end else if (ack_auto) begin
            if (mon_a0) begin
                chk("m0_adr", mon_adr, sb0);
                chk("m0_rdat", mon_d0, ~sb0);
                chk("m0_sel", {28'h0, mon_sel}, 32'hF);
                sb0 = sb0 + 32'd4; n0++;
            end
            if (mon_a1) begin
                chk("m1_adr", mon_adr, sb1);
                chk("m1_wdat", mon_dms, sb1 ^ 32'h0F0F_0000);
                chk("m1_we", {31'h0, mon_we}, 32'h1);
                chk("m1_sel", {28'h0, mon_sel}, 32'h3);
                sb1 = sb1 + 32'd4; n1++;
            end
        end
    end

    typedef struct {
        logic        nrst, c0, c1, ack;
        logic        a0, a1, scyc;
        logic [31:0] adr;
        logic [1:0]  gnt;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input logic nrst, c0, c1, ack, a0, a1, scyc,
                                input logic [31:0] adr, input logic [1:0] g);
        vec_t v;
        v.nrst = nrst; v.c0 = c0; v.c1 = c1; v.ack = ack;
        v.a0 = a0; v.a1 = a1; v.scyc = scyc; v.adr = adr; v.gnt = g;
        return v;
    endfunction

    task automatic setup(input logic [31:0] b0, input logic [31:0] b1, input logic z);
        m0_run = 1'b0; m1_run = 1'b0; use_z = z;
        m0_base = b0; m1_base = b1; m0_ld = 1'b1; m1_ld = 1'b1;
        sb_clr = 1'b1; NRST = 1'b0;
        @(posedge CLK); #1;
        NRST = 1'b1; m0_ld = 1'b0; m1_ld = 1'b0; sb_clr = 1'b0;
    endtask

    // which: 0 -> n0 reaches tgt, 1 -> n1 reaches tgt, 2 -> gnt == tgt
    task automatic wait_for(input string nm, input int which, input int tgt, input int limit);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge CLK); #1;
            if ((which == 0 && n0 >= tgt) || (which == 1 && n1 >= tgt) ||
                (which == 2 && int'(gnt) == tgt)) begin
                ok = 1'b1;
                break;
            end
        end
        chk({nm, "_reached"}, {31'h0, ok}, 32'h1);
    endtask

    initial begin
        NRST = 1'b0; m0_run = 1'b0; m1_run = 1'b0; tb_ack = 1'b0;
        ack_auto = 1'b0; use_z = 1'b0; sb_clr = 1'b1;
        m0_base = 32'h1000; m1_base = 32'h2000; m0_ld = 1'b1; m1_ld = 1'b1;
        @(posedge CLK); @(posedge CLK); #1;
        m0_ld = 1'b0; m1_ld = 1'b0; sb_clr = 1'b0;

        //            nrst  c0    c1    ack   a0    a1    scyc  adr          gnt after edge
        tbl[0]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,       2'b00);
        tbl[1]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,       2'b00);
        tbl[2]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,       2'b01);
        tbl[3]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1000,    2'b01);
        tbl[4]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1000,    2'b01);
        tbl[5]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1000,    2'b01);
        tbl[6]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1000,    2'b01);
        tbl[7]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000,    2'b10);
        tbl[8]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h2000,    2'b10);
        tbl[9]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h2000,    2'b10);
        tbl[10] = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h2000,    2'b10);
        tbl[11] = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h2000,    2'b01);
        tbl[12] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1000,    2'b00);
        tbl[13] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,       2'b00);
        tbl[14] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,       2'b10);
        tbl[15] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2000,    2'b00);
        tbl[16] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,       2'b01);
        tbl[17] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000,    2'b00);

        for (int i = 0; i < 18; i++) begin
            NRST = tbl[i].nrst; m0_run = tbl[i].c0; m1_run = tbl[i].c1; tb_ack = tbl[i].ack;
            #2;
            chk($sformatf("v%0d_m0_ack", i), {31'h0, m0_ack}, {31'h0, tbl[i].a0});
            chk($sformatf("v%0d_m1_ack", i), {31'h0, m1_ack}, {31'h0, tbl[i].a1});
            chk($sformatf("v%0d_s_cyc", i),  {31'h0, s_cyc},  {31'h0, tbl[i].scyc});
            chk($sformatf("v%0d_s_adr", i),  s_adr, tbl[i].adr);
            @(posedge CLK); #1;
            chk($sformatf("v%0d_gnt", i), {30'h0, gnt}, {30'h0, tbl[i].gnt});
        end
        tb_ack = 1'b0;
        ack_auto = 1'b1;

        // Solo writer: four sequential writes from m1
        setup(32'h0, 32'h100, 1'b0);
        m1_run = 1'b1;
        wait_for("t2_acks", 1, 4, 40);
        m1_run = 1'b0;
        chk("t2_n1", n1, 4);
        chk("t2_n0", n0, 0);
        chk("t2_next_adr", sb1, 32'h110);
        @(posedge CLK); #1;
        chk("t2_idle", {30'h0, gnt}, 32'h0);

        // Tie after reset, then direct hand-over without an idle cycle
        setup(32'h500, 32'h700, 1'b0);
        m0_run = 1'b1; m1_run = 1'b1;
        @(posedge CLK); #1;
        chk("t3_first", {30'h0, gnt}, 32'h1);
        wait_for("t3_m0", 0, 2, 40);
        m0_run = 1'b0;
        @(posedge CLK); #1;
        chk("t3_handover", {30'h0, gnt}, 32'h2);
        wait_for("t3_m1", 1, 1, 40);
        m1_run = 1'b0;
        @(posedge CLK); #1;
        chk("t3_idle", {30'h0, gnt}, 32'h0);

        // Preemption after MAX_BURST=4 acks, with resume at the next address
        setup(32'h4000, 32'h8000, 1'b0);
        m0_run = 1'b1;
        wait_for("t4_m0_two", 0, 2, 40);
        m1_run = 1'b1;
        wait_for("t4_to_m1", 2, 2, 40);
        chk("t4_m0_burst", n0, 4);
        wait_for("t4_to_m0", 2, 1, 40);
        chk("t4_m1_burst", n1, 4);
        wait_for("t4_m0_resume", 0, 5, 40);
        chk("t4_m0_fifth", sb0, 32'h4014);
        m0_run = 1'b0; m1_run = 1'b0;
        @(posedge CLK); #1;

        // No preemption when MAX_BURST=0
        begin
            int bad;
            bad = 0;
            setup(32'hA000, 32'hB000, 1'b1);
            m0_run = 1'b1;
            @(posedge CLK); #1;
            m1_run = 1'b1;
            for (int i = 0; i < 1000; i++) begin
                @(posedge CLK); #1;
                if (gnt_z !== 2'b01) bad++;
                if (n0 >= 200) break;
            end
            chk("t5_hold_gnt", bad, 0);
            chk("t5_m0_acks", n0, 200);
            chk("t5_m1_acks", n1, 0);
            m0_run = 1'b0;
            @(posedge CLK); #1;
            chk("t5_release", {30'h0, gnt_z}, 32'h2);
            m1_run = 1'b0;
            @(posedge CLK); #1;
        end

        // Reset in the middle of an m1 burst
        setup(32'h3000, 32'h6000, 1'b0);
        m1_run = 1'b1;
        wait_for("t6_m1_three", 1, 3, 40);
        m0_run = 1'b1; NRST = 1'b0;
        @(posedge CLK); #1;
        chk("t6_gnt", {30'h0, gnt}, 32'h0);
        chk("t6_s_cyc", {31'h0, s_cyc}, 32'h0);
        chk("t6_m1_ack", {31'h0, m1_ack}, 32'h0);
        NRST = 1'b1;
        @(posedge CLK); #1;
        chk("t6_m0_wins", {30'h0, gnt}, 32'h1);
        wait_for("t6_to_m1", 2, 2, 40);
        chk("t6_m0_burst", n0, 4);
        wait_for("t6_m1_resume", 1, 4, 40);
        chk("t6_m1_adr", sb1, 32'h6010);
        m0_run = 1'b0; m1_run = 1'b0;
        @(posedge CLK); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
